// File: rtl/dti_bincnt_arb.sv
// dti_bincnt_arb: round-robin arbiter that shares one binary counter between
// NUM_REQ requesters. It runs one load/count/acknowledge job per grant.
// Optional feature: define DTI_BINCNT_ARB_TIMEOUT_EN to add a RUN-state
// watchdog and the err output.
module dti_bincnt_arb #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CNT_W-1:0] req_count_to,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       ack,
    output logic                     cnt_load,
    output logic [CNT_W-1:0]         cnt_count_to,
    output logic                     cnt_count_en,
    input  logic                     cnt_done,
    output logic                     busy
`ifdef DTI_BINCNT_ARB_TIMEOUT_EN
    ,
    output logic                     err
`endif
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, ACK} state_t;

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   sel;
    logic               found;
    logic [NUM_REQ-1:0] sel_oh;

`ifdef DTI_BINCNT_ARB_TIMEOUT_EN
    // Watchdog counts RUN cycles; it must hold values up to 2^CNT_W+3.
    localparam int WD_LIMIT = (1 << CNT_W) + 4;
    localparam int WD_W     = CNT_W + 2;
    logic [WD_W-1:0] wd;
    logic            wd_expired;
    assign wd_expired = (wd == WD_W'(WD_LIMIT - 1));
`endif

    // Round-robin pick: first set req bit searching upward from ptr+1, wrapping.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!found && req[(int'(ptr) + i) % NUM_REQ]) begin
                sel   = IDX_W'((int'(ptr) + i) % NUM_REQ);
                found = 1'b1;
            end
        end
    end

    assign sel_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel;

    // Job sequencer: all outputs are registered and change with the state.
    // The load pulse coincides with the first grant cycle so the counter is
    // already loaded in the first RUN cycle; a done seen before RUN is stale.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            gnt          <= '0;
            ack          <= '0;
            cnt_load     <= 1'b0;
            cnt_count_en <= 1'b0;
            cnt_count_to <= '0;
            busy         <= 1'b0;
            idx          <= '0;
            ptr          <= IDX_W'(NUM_REQ - 1);
`ifdef DTI_BINCNT_ARB_TIMEOUT_EN
            wd           <= '0;
            err          <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt          <= sel_oh;
                        idx          <= sel;
                        cnt_count_to <= req_count_to[int'(sel)*CNT_W +: CNT_W];
                        cnt_load     <= 1'b1;
                        busy         <= 1'b1;
                        state        <= LOAD;
                    end
                end
                LOAD: begin
                    cnt_load     <= 1'b0;
                    cnt_count_en <= 1'b1;
                    state        <= RUN;
`ifdef DTI_BINCNT_ARB_TIMEOUT_EN
                    wd           <= '0;
`endif
                end
                RUN: begin
`ifdef DTI_BINCNT_ARB_TIMEOUT_EN
                    if (cnt_done || wd_expired) begin
                        cnt_count_en <= 1'b0;
                        gnt          <= '0;
                        ack          <= gnt;
                        err          <= !cnt_done;
                        state        <= ACK;
                    end else begin
                        wd <= wd + 1'b1;
                    end
`else
                    if (cnt_done) begin
                        cnt_count_en <= 1'b0;
                        gnt          <= '0;
                        ack          <= gnt;
                        state        <= ACK;
                    end
`endif
                end
                ACK: begin
                    ack   <= '0;
                    ptr   <= idx;
                    busy  <= 1'b0;
                    state <= IDLE;
`ifdef DTI_BINCNT_ARB_TIMEOUT_EN
                    err   <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
